// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM encoding and active-low 7-segment constants for the quotient display
package disp_pkg;
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to active-low {g,f,e,d,c,b,a}, blank for 10..15
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = (nib_i < 4'd10) ? SEG_DIGIT[nib_i] : SEG_BLANK;
endmodule

// File: rtl/quotient_seg_display.sv
// quotient_seg_display: captures a quotient, converts it to BCD by double-dabble and scans it onto a 4-digit display
module quotient_seg_display
    import disp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SCAN_DIV = 25000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] q_in,
    input  logic              q_valid,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp
);
    localparam int NIB   = ((DATA_W + 2) / 3 > 5) ? (DATA_W + 2) / 3 : 5;
    localparam int BCD_W = 4 * NIB;
    localparam int CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SW    = $clog2(SCAN_DIV + 1);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d, pval_q, pval_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d, ovf_q, ovf_d;
    logic [15:0]       disp_q, disp_d;
    logic [SW-1:0]     scan_q;
    logic [1:0]        sel_q;
    logic              an_en_q;
    logic [3:0]        nib, lead_zero;
    logic [6:0]        dig_seg;
    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NIB; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    // Conversion FSM; a sample arriving while busy is parked in the pending slot and restarts CONV from COMMIT
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (q_valid) begin
                sh_d    = q_in;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, sh_d} = {adj, sh_q} << 1;
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(DATA_W - 1)) ? COMMIT : CONV;
                if (q_valid) begin
                    pend_d = 1'b1;
                    pval_d = q_in;
                end
            end
            COMMIT: begin
                disp_d  = bcd_q[15:0];
                ovf_d   = |bcd_q[19:16];
                sh_d    = q_valid ? q_in : pval_q;
                bcd_d   = '0;
                cnt_d   = '0;
                pend_d  = 1'b0;
                state_d = (q_valid || pend_q) ? CONV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Conversion state and committed display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end
    // Digit scan; the first wrap only enables the anodes so digit0 is the first slot lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            sel_q   <= 2'd0;
            an_en_q <= 1'b0;
        end else if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_q  <= '0;
            an_en_q <= 1'b1;
            sel_q   <= an_en_q ? sel_q + 2'd1 : sel_q;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end
    assign nib = disp_q[4*sel_q +: 4];
    bcd_to_seg u_dec (
        .nib_i(nib),
        .seg_o(dig_seg)
    );
    // Leading-zero mask and final segment/anode selection for the active digit
    always_comb begin
        lead_zero[3] = (disp_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        an  = an_en_q ? ~(4'b0001 << sel_q) : 4'hF;
        seg = !an_en_q ? SEG_BLANK :
              ovf_q ? SEG_DASH :
              (BLANK_LZ != 0 && lead_zero[sel_q]) ? SEG_BLANK : dig_seg;
    end
    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;
    assign dp   = 1'b1;
endmodule

// File: tb/tb_quotient_seg_display.sv
// tb_quotient_seg_display: table-driven and directed checks of conversion, blanking, pending and scan behaviour
module tb_quotient_seg_display;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;
    localparam logic [6:0] D [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    typedef struct packed {
        logic [15:0]      q;
        logic             ovf;
        logic [3:0][6:0]  sa;
        logic [3:0][6:0]  sz;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] q_in;
    logic        q_valid;
    logic        busy_a, ovf_a, dp_a, busy_z, ovf_z, dp_z;
    logic [6:0]  seg_a, seg_z;
    logic [3:0]  an_a, an_z;
    int          checks = 0;
    int          fails = 0;
    vec_t        vt [9];
    logic [3:0][6:0] ra, rz;
    quotient_seg_display #(.DATA_W(16), .SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_valid(q_valid),
        .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a), .dp(dp_a)
    );
    quotient_seg_display #(.DATA_W(16), .SCAN_DIV(4), .BLANK_LZ(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_valid(q_valid),
        .busy(busy_z), .ovf(ovf_z), .seg(seg_z), .an(an_z), .dp(dp_z)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask
    task automatic read_display(output logic [3:0][6:0] sa, output logic [3:0][6:0] sz);
        logic [3:0] fa, fz, p;
        fa = '0;
        fz = '0;
        sa = '0;
        sz = '0;
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < 4; k++) begin
                p = 4'b0001 << k;
                p = ~p;
                if (an_a == p) begin sa[k] = seg_a; fa[k] = 1'b1; end
                if (an_z == p) begin sz[k] = seg_z; fz[k] = 1'b1; end
            end
            tick();
        end
        check("scan found a", {28'd0, fa}, 32'hF);
        check("scan found z", {28'd0, fz}, 32'hF);
    endtask
    task automatic pulse(input logic [15:0] v);
        q_in = v;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
    endtask
    task automatic wait_done();
        int n;
        n = 0;
        while (busy_a && n < 100) begin
            tick();
            n++;
        end
        check("conv done", {31'd0, busy_a}, 32'd0);
    endtask
    initial begin
        int n;
        logic ok;
        logic [3:0] p;
        rst_n = 1'b0;
        q_valid = 1'b0;
        q_in = '0;
        vt[0] = '{16'd42,    1'b0, {BL, BL, D[4], D[2]},   {D[0], D[0], D[4], D[2]}};
        vt[1] = '{16'd0,     1'b0, {BL, BL, BL, D[0]},     {D[0], D[0], D[0], D[0]}};
        vt[2] = '{16'd12345, 1'b1, {DS, DS, DS, DS},       {DS, DS, DS, DS}};
        vt[3] = '{16'd9999,  1'b0, {D[9], D[9], D[9], D[9]}, {D[9], D[9], D[9], D[9]}};
        vt[4] = '{16'd7,     1'b0, {BL, BL, BL, D[7]},     {D[0], D[0], D[0], D[7]}};
        vt[5] = '{16'd1000,  1'b0, {D[1], D[0], D[0], D[0]}, {D[1], D[0], D[0], D[0]}};
        vt[6] = '{16'd65535, 1'b1, {DS, DS, DS, DS},       {DS, DS, DS, DS}};
        vt[7] = '{16'd105,   1'b0, {BL, D[1], D[0], D[5]}, {D[0], D[1], D[0], D[5]}};
        vt[8] = '{16'd10000, 1'b1, {DS, DS, DS, DS},       {DS, DS, DS, DS}};
        repeat (3) tick();
        check("rst busy", {31'd0, busy_a}, 32'd0);
        check("rst ovf", {31'd0, ovf_a}, 32'd0);
        check("rst seg", {25'd0, seg_a}, 32'h7F);
        check("rst an", {28'd0, an_a}, 32'hF);
        check("rst dp", {31'd0, dp_a}, 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (an_a == 4'hF && n < 50) begin
            n++;
            tick();
        end
        check("first slot blank cycles", n, 4);
        for (int s = 0; s < 16; s++) begin
            p = 4'b0001 << (s % 4);
            p = ~p;
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (an_a !== p) ok = 1'b0;
                tick();
            end
            check($sformatf("scan slot %0d", s), {31'd0, ok}, 32'd1);
        end
        pulse(16'd42);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick();
        end
        check("busy length", n, 17);
        for (int i = 0; i < 9; i++) begin
            pulse(vt[i].q);
            wait_done();
            check($sformatf("v%0d ovf", i), {31'd0, ovf_a}, {31'd0, vt[i].ovf});
            read_display(ra, rz);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("v%0d lz d%0d", i, k), {25'd0, ra[k]}, {25'd0, vt[i].sa[k]});
                check($sformatf("v%0d nolz d%0d", i, k), {25'd0, rz[k]}, {25'd0, vt[i].sz[k]});
            end
        end
        pulse(16'd7);
        for (int i = 1; i <= 17; i++) begin
            if (i == 2) begin q_in = 16'd50; q_valid = 1'b1; end
            if (i == 4) begin q_in = 16'd63; q_valid = 1'b1; end
            tick();
            q_valid = 1'b0;
        end
        check("pending busy held", {31'd0, busy_a}, 32'd1);
        ra = '0;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 4; k++) begin
                p = 4'b0001 << k;
                p = ~p;
                if (an_a == p) ra[k] = seg_a;
            end
            tick();
        end
        check("between commits", ra, {BL, BL, BL, D[7]});
        check("second conv busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("second conv done", {31'd0, busy_a}, 32'd0);
        read_display(ra, rz);
        check("pending last wins", ra, {BL, BL, D[6], D[3]});
        pulse(16'd5);
        repeat (16) tick();
        pulse(16'd88);
        check("commit coincident busy", {31'd0, busy_a}, 32'd1);
        wait_done();
        read_display(ra, rz);
        check("commit coincident value", ra, {BL, BL, D[8], D[8]});
        pulse(16'd1234);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midconv rst busy", {31'd0, busy_a}, 32'd0);
        check("midconv rst seg", {25'd0, seg_a}, 32'h7F);
        check("midconv rst an", {28'd0, an_a}, 32'hF);
        check("midconv rst dp", {31'd0, dp_a}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst idle", {31'd0, busy_a}, 32'd0);
        read_display(ra, rz);
        check("post rst display", ra, {BL, BL, BL, D[0]});
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
